// File: rtl/pair_seq_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : pair_seq_tx_if
// Description : Handshake and serial-stream bundle for pair_seq_tx. The
//               master side requests frames and consumes the bit stream;
//               the slave side is the transmitter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pair_seq_tx_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             bit_out;
    logic             bit_valid;
    logic             last;
    logic             exp_det;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    modport master (
        output load, data,
        input  ready, bit_out, bit_valid, last, exp_det, match_cnt, done
    );

    modport slave (
        input  load, data,
        output ready, bit_out, bit_valid, last, exp_det, match_cnt, done
    );
endinterface
`default_nettype wire

// File: rtl/pair_seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : pair_seq_tx
// Description : Loads a WIDTH-bit word on a ready/load handshake and shifts
//               it out LSB-first. A shadow pair-detection FSM runs on the
//               outgoing bits so every bit carries the detector output
//               expected for it, and a per-frame match count is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_seq_tx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pair_seq_tx_if.slave bus
);
    localparam int              c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // T0: nothing pending, T1: a 1 is pending, T2: a 0 is pending
    typedef enum logic [1:0] {
        TRK_T0 = 2'd0,
        TRK_T1 = 2'd1,
        TRK_T2 = 2'd2
    } trk_t;

    state_t             r_state;
    trk_t               r_trk;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]   r_match_cnt;

    logic w_valid;
    logic w_bit;
    logic w_exp_det;
    trk_t w_trk_nxt;

    assign w_valid   = (r_state == ST_SHIFT);
    assign w_bit     = w_valid & r_shreg[0];
    assign w_exp_det = w_valid & (((r_trk == TRK_T1) &  w_bit) |
                                  ((r_trk == TRK_T2) & ~w_bit));

    // Tracker next state; a detection sends it back to T0 so pairs never overlap
    always_comb begin
        w_trk_nxt = TRK_T0;
        case (r_trk)
            TRK_T0:  w_trk_nxt = w_bit ? TRK_T1 : TRK_T2;
            TRK_T1:  w_trk_nxt = w_bit ? TRK_T0 : TRK_T2;
            TRK_T2:  w_trk_nxt = w_bit ? TRK_T1 : TRK_T0;
            default: w_trk_nxt = TRK_T0;
        endcase
    end

    // Frame controller: accept in IDLE, shift WIDTH bits, one DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_trk       <= TRK_T0;
            r_shreg     <= '0;
            r_idx       <= '0;
            r_match_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        r_shreg     <= bus.data;
                        r_idx       <= '0;
                        r_match_cnt <= '0;
                        r_trk       <= TRK_T0;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shreg     <= r_shreg >> 1;
                    r_idx       <= r_idx + c_IDX_W'(1);
                    r_trk       <= w_trk_nxt;
                    r_match_cnt <= r_match_cnt + {{(CNT_W-1){1'b0}}, w_exp_det};
                    if (r_idx == c_IDX_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (r_state == ST_IDLE);
    assign bus.bit_out   = w_bit;
    assign bus.bit_valid = w_valid;
    assign bus.last      = w_valid & (r_idx == c_IDX_LAST);
    assign bus.exp_det   = w_exp_det;
    assign bus.match_cnt = r_match_cnt;
    assign bus.done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pair_seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pair_seq_tx
// Description : Scoreboard bench for pair_seq_tx. Expected bits, detector
//               flags and per-frame counts are queued when a frame is
//               accepted and popped as the transmitter emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_seq_tx;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic rst;

    pair_seq_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pair_seq_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    logic [2:0]       bit_q[$];   // {bit_out, exp_det, last}
    logic [CNT_W-1:0] cnt_q[$];
    logic [CNT_W-1:0] last_cnt;
    logic [2:0]       mon_e;
    logic [CNT_W-1:0] mon_c;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: non-overlapping pairs of equal adjacent bits
    task automatic push_frame(input logic [WIDTH-1:0] d);
        logic have;
        logic prev;
        logic det;
        logic b;
        int   cnt;
        have = 1'b0;
        prev = 1'b0;
        cnt  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            b   = d[i];
            det = 1'b0;
            if (have && (b == prev)) begin
                det  = 1'b1;
                have = 1'b0;
                cnt++;
            end else begin
                have = 1'b1;
                prev = b;
            end
            bit_q.push_back({b, det, (i == WIDTH - 1)});
        end
        cnt_q.push_back(CNT_W'(cnt));
        last_cnt = CNT_W'(cnt);
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bit_valid) begin
                if (bit_q.size() == 0) begin
                    check_val("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    mon_e = bit_q.pop_front();
                    check_val("bit_out", 32'(bus.bit_out), 32'(mon_e[2]));
                    check_val("exp_det", 32'(bus.exp_det), 32'(mon_e[1]));
                    check_val("last",    32'(bus.last),    32'(mon_e[0]));
                end
            end else begin
                check_val("idle_bit_out", 32'(bus.bit_out), 32'd0);
                check_val("idle_exp_det", 32'(bus.exp_det), 32'd0);
                check_val("idle_last",    32'(bus.last),    32'd0);
            end
            check_val("ready", 32'(bus.ready), 32'(!bus.bit_valid && !bus.done));
            if (bus.done) begin
                done_seen++;
                if (cnt_q.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_c = cnt_q.pop_front();
                    check_val("match_cnt_done", 32'(bus.match_cnt), 32'(mon_c));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"},     32'(bus.ready),     32'd1);
        check_val({tag, "_bit_out"},   32'(bus.bit_out),   32'd0);
        check_val({tag, "_bit_valid"}, 32'(bus.bit_valid), 32'd0);
        check_val({tag, "_last"},      32'(bus.last),      32'd0);
        check_val({tag, "_exp_det"},   32'(bus.exp_det),   32'd0);
        check_val({tag, "_match_cnt"}, 32'(bus.match_cnt), 32'd0);
        check_val({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("timeout_ready", 32'd0, 32'd1);
    endtask

    // Returns #1 after the accepting edge, i.e. during bit 0 of the frame
    task automatic send(input logic [WIDTH-1:0] d);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            bus.load = 1'b1;
            bus.data = d;
            @(posedge clk);
            push_frame(d);
            #1 bus.load = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (bit_q.size() != 0 || cnt_q.size() != 0); i++) begin
            @(posedge clk);
        end
        check_val("drain", 32'(bit_q.size() + cnt_q.size()), 32'd0);
    endtask

    initial begin
        bit ok;
        int d0;
        rst      = 1'b1;
        bus.load = 1'b0;
        bus.data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed frames
        send(16'h0000);
        drain();
        repeat (3) @(negedge clk);
        check_val("cnt_hold", 32'(bus.match_cnt), 32'(last_cnt));

        send(16'hFFFF);
        drain();
        send(16'h5555);
        drain();
        repeat (2) @(negedge clk);
        check_val("cnt_hold_zero", 32'(bus.match_cnt), 32'(last_cnt));
        send(16'h5772);
        drain();

        // Ignored load mid-frame, then reset abort at bit 7
        send(16'h00F0);
        repeat (4) @(posedge clk);
        #1;
        bus.load = 1'b1;
        bus.data = 16'h0000;
        @(posedge clk);
        #1 bus.load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        bit_q.delete();
        cnt_q.delete();
        d0 = done_seen;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_no_done", 32'(done_seen), 32'(d0));
        check_reset_outputs("post_abort");
        send(16'h5772);
        drain();

        // Back-to-back frames with load held high
        bus.load = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_ready(ok);
            if (!ok) break;
            bus.data = (f % 2 == 1) ? 16'hFFFF : 16'h0000;
            @(posedge clk);
            push_frame(bus.data);
            @(negedge clk);
            check_val("b2b_ready_1cyc", 32'(bus.ready), 32'd0);
        end
        wait_ready(ok);
        bus.load = 1'b0;
        drain();
        check_val("b2b_cnt_hold", 32'(bus.match_cnt), 32'(last_cnt));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
